sop_arbiter: RTL

- Shares one sum_of_products instance (multiplier bank plus adder tree, fixed latency, no tag or backpressure) between REQ requesters.
- Round-robin arbitration picks one operand-vector pair per cycle and drives the SOP input port.
- A tag FIFO records the requester ID of every issued operation and is popped when each SOP result returns.
- Sits between the CNN window/feature fetch engines and the shared SOP datapath.

---
 rtl/sop_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sop_arbiter.sv
// sop_arbiter: round-robin front end that lets REQ requesters share one
// fixed-latency sum_of_products datapath. Each accepted request is issued to
// the SOP one cycle later, and its requester ID is queued in a tag FIFO so the
// in-order SOP result can be routed back to its owner.
// Optional feature macro: SOP_ARB_ERR_EN (sticky underflow flag plus
// simulation assertions). With it undefined, err is tied low.

module sop_arbiter #(
   parameter int EXP    = 8,
   parameter int MANT   = 7,
   parameter int WIDTHF = 1 + EXP + MANT,
   parameter int NUM    = 9,
   parameter int REQ    = 4,
   parameter int DEPTH  = 16,
   parameter int IDW    = ($clog2(REQ) > 1) ? $clog2(REQ) : 1,
   parameter int CNTW   = $clog2(DEPTH + 1)
) (
   input  logic                                 clock,
   input  logic                                 clock_areset_n,
   input  logic [REQ-1:0]                       req_valid,
   output logic [REQ-1:0]                       req_ready,
   input  logic [REQ-1:0][NUM-1:0][WIDTHF-1:0]  req_dataa,
   input  logic [REQ-1:0][NUM-1:0][WIDTHF-1:0]  req_datab,
   output logic                                 sop_data_valid,
   output logic [NUM-1:0][WIDTHF-1:0]           sop_dataa,
   output logic [NUM-1:0][WIDTHF-1:0]           sop_datab,
   input  logic                                 sop_result_valid,
   input  logic [WIDTHF-1:0]                    sop_result,
   output logic                                 result_valid,
   output logic [IDW-1:0]                       result_id,
   output logic [WIDTHF-1:0]                    result,
   output logic [CNTW-1:0]                      outstanding,
   output logic                                 busy,
   output logic                                 err
);

   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDW-1:0]              rrPtr_q, rrPtr_d;
   logic [PTRW-1:0]             wrPtr_q, rdPtr_q;
   logic [CNTW-1:0]             count_q, count_d;
   logic [IDW-1:0]              tagMem_q [DEPTH];
   logic                        issueValid_q;
   logic [NUM-1:0][WIDTHF-1:0]  issueA_q, issueB_q;
   logic                        resValid_q;
   logic [IDW-1:0]              resId_q;
   logic [WIDTHF-1:0]           res_q;

   logic [IDW-1:0]              grantIdx, lowPick, highPick;
   logic                        highFound;
   logic                        anyValid, fifoFull, fifoEmpty, doIssue, doPop;

   assign anyValid  = |req_valid;
   assign fifoFull  = (count_q == CNTW'(DEPTH));
   assign fifoEmpty = (count_q == '0);
   assign doIssue   = anyValid && !fifoFull;
   assign doPop     = sop_result_valid && !fifoEmpty;

   // Round-robin pick: lowest valid index at or above the pointer, else wrap to the lowest valid index.
   always_comb begin
      lowPick   = '0;
      highPick  = '0;
      highFound = 1'b0;
      for (int i = REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lowPick = IDW'(i);
            if (IDW'(i) >= rrPtr_q) begin
               highPick  = IDW'(i);
               highFound = 1'b1;
            end
         end
      end
      grantIdx = highFound ? highPick : lowPick;
   end

   // One-hot ready to the granted requester, withheld entirely while the tag FIFO is full.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < REQ; i++) begin
         req_ready[i] = doIssue && (grantIdx == IDW'(i));
      end
   end

   // Next pointer and in-flight count; an issue and a pop in the same cycle cancel out.
   always_comb begin
      rrPtr_d = (grantIdx == IDW'(REQ - 1)) ? '0 : grantIdx + IDW'(1);
      count_d = count_q;
      case ({doIssue, doPop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   // Tag storage: holds the requester ID of every issued operation, no reset needed.
   always_ff @(posedge clock) begin
      if (doIssue) begin
         tagMem_q[wrPtr_q] <= grantIdx;
      end
   end

   // Arbitration state, issue register towards the SOP and routed result register.
   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         rrPtr_q      <= '0;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
         issueValid_q <= 1'b0;
         issueA_q     <= '0;
         issueB_q     <= '0;
         resValid_q   <= 1'b0;
         resId_q      <= '0;
         res_q        <= '0;
      end else begin
         count_q      <= count_d;
         issueValid_q <= doIssue;
         resValid_q   <= doPop;
         if (doIssue) begin
            rrPtr_q  <= rrPtr_d;
            wrPtr_q  <= wrPtr_q + PTRW'(1);
            issueA_q <= req_dataa[grantIdx];
            issueB_q <= req_datab[grantIdx];
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PTRW'(1);
            resId_q <= tagMem_q[rdPtr_q];
            res_q   <= sop_result;
         end
      end
   end

   assign sop_data_valid = issueValid_q;
   assign sop_dataa      = issueA_q;
   assign sop_datab      = issueB_q;
   assign result_valid   = resValid_q;
   assign result_id      = resId_q;
   assign result         = res_q;
   assign outstanding    = count_q;
   assign busy           = (count_q != '0);

`ifdef SOP_ARB_ERR_EN
   logic err_q;

   // Sticky flag for a SOP result that arrives with no operation in flight.
   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         err_q <= 1'b0;
      end else if (sop_result_valid && fifoEmpty) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;

   readyWhileFull: assert property (@(posedge clock) disable iff (!clock_areset_n)
      !((|req_ready) && fifoFull));

   countInRange: assert property (@(posedge clock) disable iff (!clock_areset_n)
      count_q <= CNTW'(DEPTH));
`else
   assign err = 1'b0;
`endif

endmodule
